// File: rtl/conv_8_to_16_32.sv
// conv_8_to_16_32
//   Byte-to-word reassembler. Collects an SOF-framed byte stream (MSB first)
//   into SIZE-bit words and presents them on a valid/ready output register.
//   Reports framing errors (ALIGN_ERR pulse) and dropped words (OVERFLOW, sticky).
// Ports:
//   PCLK      - clock, rising edge
//   RESET     - synchronous active-high reset
//   DATA_IN   - input byte
//   VALID_IN  - DATA_IN/SOF_IN valid this cycle (always accepted)
//   SOF_IN    - DATA_IN is the first byte (MSB) of a word
//   READY_IN  - downstream accepts DATA_OUT when VALID_OUT && READY_IN
//   DATA_OUT  - assembled word (registered)
//   VALID_OUT - DATA_OUT holds an unconsumed word
//   ALIGN_ERR - one-cycle pulse: SOF arrived mid-word
//   OVERFLOW  - sticky: a completed word was dropped because the output was full
module conv_8_to_16_32 #(
  parameter int SIZE   = 16,
  parameter int NBYTES = SIZE / 8
) (
  input  logic            PCLK,
  input  logic            RESET,
  input  logic [7:0]      DATA_IN,
  input  logic            VALID_IN,
  input  logic            SOF_IN,
  input  logic            READY_IN,
  output logic [SIZE-1:0] DATA_OUT,
  output logic            VALID_OUT,
  output logic            ALIGN_ERR,
  output logic            OVERFLOW
);

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  // Count value before the shift that means "this byte completes the word".
  localparam logic [1:0] LAST_CNT = 2'(NBYTES - 1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [1:0]      cnt_r;
  logic [1:0]      cnt_nxt_s;
  // Only the bytes preceding the final one need storage; the final byte is
  // concatenated straight from DATA_IN when the word completes.
  logic [SIZE-9:0] shift_r;
  logic [SIZE-9:0] shift_nxt_s;
  logic            word_done_s;
  logic            align_s;
  logic [SIZE-1:0] pend_r;
  logic            pend_vld_r;
  logic [SIZE-1:0] data_out_r;
  logic            valid_out_r;
  logic            align_err_r;
  logic            overflow_r;

  // FSM state register.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state_r <= ST_HUNT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HUNT: begin
        if (VALID_IN && SOF_IN) begin
          state_nxt_s = ST_COLLECT;
        end else begin
          state_nxt_s = ST_HUNT;
        end
      end
      ST_COLLECT: begin
        if (VALID_IN && !SOF_IN && (cnt_r == LAST_CNT)) begin
          state_nxt_s = ST_HUNT;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      default: state_nxt_s = ST_HUNT;
    endcase
  end

  // FSM output logic: byte count, shift register, word completion and framing error.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    shift_nxt_s = shift_r;
    word_done_s = 1'b0;
    align_s     = 1'b0;
    case (state_r)
      ST_HUNT: begin
        if (VALID_IN && SOF_IN) begin
          cnt_nxt_s   = 2'd1;
          shift_nxt_s = (SIZE-8)'(DATA_IN);
        end else begin
          cnt_nxt_s   = cnt_r;
          shift_nxt_s = shift_r;
        end
      end
      ST_COLLECT: begin
        if (VALID_IN && SOF_IN) begin
          // Restart on the new SOF byte; the partial word is abandoned.
          align_s     = 1'b1;
          cnt_nxt_s   = 2'd1;
          shift_nxt_s = (SIZE-8)'(DATA_IN);
        end else if (VALID_IN) begin
          if (cnt_r == LAST_CNT) begin
            word_done_s = 1'b1;
            cnt_nxt_s   = 2'd0;
          end else begin
            cnt_nxt_s   = cnt_r + 2'd1;
            shift_nxt_s = (SIZE-8)'({shift_r, DATA_IN});
          end
        end else begin
          cnt_nxt_s   = cnt_r;
          shift_nxt_s = shift_r;
        end
      end
      default: begin
        cnt_nxt_s   = 2'd0;
        shift_nxt_s = '0;
      end
    endcase
  end

  // Datapath registers: byte count, shift register, completed-word stage, error pulse.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      cnt_r       <= 2'd0;
      shift_r     <= '0;
      pend_r      <= '0;
      pend_vld_r  <= 1'b0;
      align_err_r <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      shift_r     <= shift_nxt_s;
      align_err_r <= align_s;
      pend_vld_r  <= word_done_s;
      if (word_done_s) begin
        pend_r <= {shift_r, DATA_IN};
      end else begin
        pend_r <= pend_r;
      end
    end
  end

  // Output register with valid/ready handshake; a word arriving while the
  // register is full and not being consumed is dropped and flagged.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      data_out_r  <= '0;
      valid_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (pend_vld_r) begin
        if (!valid_out_r || READY_IN) begin
          data_out_r  <= pend_r;
          valid_out_r <= 1'b1;
        end else begin
          overflow_r  <= 1'b1;
        end
      end else if (valid_out_r && READY_IN) begin
        valid_out_r <= 1'b0;
      end else begin
        valid_out_r <= valid_out_r;
      end
    end
  end

  assign DATA_OUT  = data_out_r;
  assign VALID_OUT = valid_out_r;
  assign ALIGN_ERR = align_err_r;
  assign OVERFLOW  = overflow_r;

endmodule

// File: tb/tb_conv_8_to_16_32.sv
// Testbench for conv_8_to_16_32. A 16-bit and a 32-bit instance share the same
// input stream; a byte-list reference model predicts both every cycle, and
// directed scenarios add fixed expected values.
module tb_conv_8_to_16_32;

  logic        clk;
  logic        rst_s;
  logic [7:0]  data_s;
  logic        valid_s;
  logic        sof_s;
  logic        ready_s;

  logic [15:0] d16_s;
  logic        v16_s, ae16_s, of16_s;
  logic [31:0] d32_s;
  logic        v32_s, ae32_s, of32_s;

  int n_vec;
  int n_err;

  // Reference model state, index 0 = 16-bit, index 1 = 32-bit.
  int          m_cnt [2];
  logic [7:0]  m_b   [2][4];
  logic        m_pend[2];
  logic [31:0] m_pw  [2];
  logic [31:0] m_do  [2];
  logic        m_vo  [2];
  logic        m_ae  [2];
  logic        m_ov  [2];

  conv_8_to_16_32 #(.SIZE(16)) dut16 (
    .PCLK(clk), .RESET(rst_s), .DATA_IN(data_s), .VALID_IN(valid_s),
    .SOF_IN(sof_s), .READY_IN(ready_s), .DATA_OUT(d16_s), .VALID_OUT(v16_s),
    .ALIGN_ERR(ae16_s), .OVERFLOW(of16_s)
  );

  conv_8_to_16_32 #(.SIZE(32)) dut32 (
    .PCLK(clk), .RESET(rst_s), .DATA_IN(data_s), .VALID_IN(valid_s),
    .SOF_IN(sof_s), .READY_IN(ready_s), .DATA_OUT(d32_s), .VALID_OUT(v32_s),
    .ALIGN_ERR(ae32_s), .OVERFLOW(of32_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one rising edge with the given inputs.
  task automatic model_edge(input logic v, input logic s, input logic [7:0] d,
                            input logic r, input logic rst);
    for (int k = 0; k < 2; k++) begin
      int nb;
      nb = (k == 0) ? 2 : 4;
      if (rst) begin
        m_cnt[k] = 0; m_pend[k] = 1'b0; m_pw[k] = 32'd0; m_do[k] = 32'd0;
        m_vo[k] = 1'b0; m_ae[k] = 1'b0; m_ov[k] = 1'b0;
      end else begin
        if (m_pend[k]) begin
          if (!m_vo[k] || r) begin
            m_do[k] = m_pw[k];
            m_vo[k] = 1'b1;
          end else begin
            m_ov[k] = 1'b1;
          end
        end else if (m_vo[k] && r) begin
          m_vo[k] = 1'b0;
        end
        m_ae[k]   = v && s && (m_cnt[k] > 0);
        m_pend[k] = 1'b0;
        if (v) begin
          if (s) begin
            m_b[k][0] = d;
            m_cnt[k]  = 1;
          end else if (m_cnt[k] > 0) begin
            m_b[k][m_cnt[k]] = d;
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == nb) begin
              m_pw[k] = 32'd0;
              for (int i = 0; i < nb; i++) m_pw[k] = (m_pw[k] << 8) | 32'(m_b[k][i]);
              m_pend[k] = 1'b1;
              m_cnt[k]  = 0;
            end
          end
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare both instances.
  task automatic step(input logic v, input logic s, input logic [7:0] d,
                      input logic r, input logic rst);
    @(negedge clk);
    valid_s = v; sof_s = s; data_s = d; ready_s = r; rst_s = rst;
    @(posedge clk);
    model_edge(v, s, d, r, rst);
    #1;
    n_vec++;
    if ({v16_s, ae16_s, of16_s} !== {m_vo[0], m_ae[0], m_ov[0]} || d16_s !== m_do[0][15:0]) begin
      n_err++;
      $display("FAIL model16 @%0t: got v=%b ae=%b of=%b d=%h expected v=%b ae=%b of=%b d=%h",
               $time, v16_s, ae16_s, of16_s, d16_s, m_vo[0], m_ae[0], m_ov[0], m_do[0][15:0]);
    end
    n_vec++;
    if ({v32_s, ae32_s, of32_s} !== {m_vo[1], m_ae[1], m_ov[1]} || d32_s !== m_do[1]) begin
      n_err++;
      $display("FAIL model32 @%0t: got v=%b ae=%b of=%b d=%h expected v=%b ae=%b of=%b d=%h",
               $time, v32_s, ae32_s, of32_s, d32_s, m_vo[1], m_ae[1], m_ov[1], m_do[1]);
    end
  endtask

  task automatic idle(input logic r);
    step(1'b0, 1'b0, 8'h00, r, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({v16_s, ae16_s, of16_s, v32_s, ae32_s, of32_s} !== 6'b0 || d16_s !== 16'h0 || d32_s !== 32'h0) begin
      n_err++;
      $display("FAIL reset: got flags=%b d16=%h d32=%h expected all zero",
               {v16_s, ae16_s, of16_s, v32_s, ae32_s, of32_s}, d16_s, d32_s);
    end
  endtask

  task automatic test_basic16();
    do_reset();
    step(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);
    n_vec++;
    if (v16_s !== 1'b0) begin
      n_err++; $display("FAIL t1_latency: got valid=%b expected 0", v16_s);
    end
    idle(1'b1);
    n_vec++;
    if (v16_s !== 1'b1 || d16_s !== 16'hA53C) begin
      n_err++; $display("FAIL t1_word: got v=%b d=%h expected v=1 d=a53c", v16_s, d16_s);
    end
    idle(1'b1);
    n_vec++;
    if (v16_s !== 1'b0) begin
      n_err++; $display("FAIL t1_pulse: got valid=%b expected 0", v16_s);
    end
  endtask

  task automatic test_gaps32();
    int pulses;
    logic [7:0] seq [7];
    logic       sofq [7];
    logic       vq [7];
    seq  = '{8'hDE, 8'hAD, 8'h00, 8'h00, 8'h00, 8'hBE, 8'hEF};
    sofq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vq   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(vq[i], sofq[i], seq[i], 1'b1, 1'b0);
      if (v32_s) pulses++;
    end
    idle(1'b1);
    n_vec++;
    if (v32_s !== 1'b1 || d32_s !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL t2_word: got v=%b d=%h expected v=1 d=deadbeef", v32_s, d32_s);
    end
    pulses += 1;
    idle(1'b1);
    if (v32_s) pulses++;
    n_vec++;
    if (pulses != 1) begin
      n_err++; $display("FAIL t2_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_hunt16();
    int ae_seen;
    logic [7:0] seq [4];
    logic       sofq [4];
    seq  = '{8'h11, 8'h22, 8'h33, 8'h44};
    sofq = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    ae_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, sofq[i], seq[i], 1'b1, 1'b0);
      if (ae16_s || v16_s) ae_seen++;
    end
    idle(1'b1);
    n_vec++;
    if (v16_s !== 1'b1 || d16_s !== 16'h3344 || ae_seen != 0) begin
      n_err++; $display("FAIL t3_hunt: got v=%b d=%h early=%0d expected v=1 d=3344 early=0",
                        v16_s, d16_s, ae_seen);
    end
  endtask

  task automatic test_align32();
    do_reset();
    step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
    n_vec++;
    if (ae32_s !== 1'b1) begin
      n_err++; $display("FAIL t4_align_pulse: got %b expected 1", ae32_s);
    end
    step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    n_vec++;
    if (ae32_s !== 1'b0) begin
      n_err++; $display("FAIL t4_align_clear: got %b expected 0", ae32_s);
    end
    step(1'b1, 1'b0, 8'h88, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
    idle(1'b1);
    n_vec++;
    if (v32_s !== 1'b1 || d32_s !== 32'h66778899) begin
      n_err++; $display("FAIL t4_word: got v=%b d=%h expected v=1 d=66778899", v32_s, d32_s);
    end
  endtask

  task automatic test_overflow16();
    do_reset();
    step(1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h34, 1'b0, 1'b0);
    idle(1'b0);
    n_vec++;
    if (v16_s !== 1'b1 || d16_s !== 16'h1234 || of16_s !== 1'b0) begin
      n_err++; $display("FAIL t5_first: got v=%b d=%h of=%b expected v=1 d=1234 of=0",
                        v16_s, d16_s, of16_s);
    end
    step(1'b1, 1'b1, 8'h56, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h78, 1'b0, 1'b0);
    idle(1'b0);
    n_vec++;
    if (v16_s !== 1'b1 || d16_s !== 16'h1234 || of16_s !== 1'b1) begin
      n_err++; $display("FAIL t5_overflow: got v=%b d=%h of=%b expected v=1 d=1234 of=1",
                        v16_s, d16_s, of16_s);
    end
    idle(1'b1);
    n_vec++;
    if (v16_s !== 1'b0 || of16_s !== 1'b1 || d16_s !== 16'h1234) begin
      n_err++; $display("FAIL t5_drain: got v=%b of=%b d=%h expected v=0 of=1 d=1234",
                        v16_s, of16_s, d16_s);
    end
  endtask

  task automatic test_midword_reset();
    do_reset();
    step(1'b1, 1'b1, 8'hAB, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b1, 8'hCD, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'hEF, 1'b1, 1'b0);
    idle(1'b1);
    n_vec++;
    if (v16_s !== 1'b1 || d16_s !== 16'hCDEF || ae16_s !== 1'b0 || of16_s !== 1'b0) begin
      n_err++; $display("FAIL t6_reset: got v=%b d=%h ae=%b of=%b expected v=1 d=cdef ae=0 of=0",
                        v16_s, d16_s, ae16_s, of16_s);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    do_reset();
    pulses = 0;
    for (int w = 0; w < 4; w++) begin
      step(1'b1, 1'b1, 8'(8'h10 + w), 1'b1, 1'b0);
      if (v16_s) pulses++;
      step(1'b1, 1'b0, 8'(8'hF0 + w), 1'b1, 1'b0);
      if (v16_s) pulses++;
    end
    idle(1'b1);
    if (v16_s) pulses++;
    idle(1'b1);
    if (v16_s) pulses++;
    n_vec++;
    if (pulses != 4 || of16_s !== 1'b0 || d16_s !== 16'h13F3) begin
      n_err++; $display("FAIL t7_b2b: got pulses=%0d of=%b last=%h expected pulses=4 of=0 last=13f3",
                        pulses, of16_s, d16_s);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), 8'($urandom),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) == 0));
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_s = 1'b1; data_s = 8'h00; valid_s = 1'b0; sof_s = 1'b0; ready_s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_pend[k] = 1'b0; m_pw[k] = 32'd0; m_do[k] = 32'd0;
      m_vo[k] = 1'b0; m_ae[k] = 1'b0; m_ov[k] = 1'b0;
      for (int i = 0; i < 4; i++) m_b[k][i] = 8'h00;
    end
    test_reset();
    test_basic16();
    test_gaps32();
    test_hunt16();
    test_align32();
    test_overflow16();
    test_midword_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
